// File: rtl/fp_add_arbiter.sv
// fp_add_arbiter: round-robin front end that shares one pipelined FP32 adder
// among NUM_REQ requesters. Every issued operation carries a {valid, id} tag
// down a shadow pipeline so the adder result is steered back to its issuer.
// All state updates on the falling edge of clk_n, matching the adder.
// Optional build macro FP_ARB_PERF_EN adds saturating issue/stall counters.
module fp_add_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int ADD_LATENCY = 6,
  parameter int ID_W        = 2
) (
  input  logic                    clk_n,
  input  logic                    rst_n,
  input  logic                    flush,
  input  logic [NUM_REQ-1:0]      req_valid,
  input  logic [NUM_REQ-1:0]      req_sub,
  input  logic [NUM_REQ*32-1:0]   req_a,
  input  logic [NUM_REQ*32-1:0]   req_b,
  output logic [NUM_REQ-1:0]      req_ready,
  output logic [31:0]             add_a,
  output logic [31:0]             add_b,
  input  logic [31:0]             add_result,
  output logic [NUM_REQ-1:0]      rsp_valid,
  output logic [ID_W-1:0]         rsp_id,
  output logic [31:0]             rsp_data,
  output logic [3:0]              inflight
`ifdef FP_ARB_PERF_EN
  ,
  output logic [31:0]             perf_issue_cnt,
  output logic [31:0]             perf_stall_cnt
`endif
);

  // One tag stage per adder stage plus the stage that lines up with the
  // registered response.
  localparam int TAG_DEPTH = ADD_LATENCY + 1;

  logic [ID_W-1:0]      rr_ptr;
  logic [ID_W-1:0]      scan_idx;
  logic [ID_W-1:0]      win_id;
  logic                 req_any;
  logic                 grant;
  logic [31:0]          a_arr [NUM_REQ];
  logic [31:0]          b_arr [NUM_REQ];
  logic [TAG_DEPTH-1:0] tag_valid;
  logic [ID_W-1:0]      tag_id [TAG_DEPTH];
  logic [NUM_REQ-1:0]   rsp_onehot;
  logic                 tag_exit;

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign a_arr[g] = req_a[32*g +: 32];
    assign b_arr[g] = req_b[32*g +: 32];
  end

  // Round-robin search starting one past the last winner; flush masks the grant.
  always_comb begin
    req_any   = 1'b0;
    win_id    = '0;
    scan_idx  = '0;
    req_ready = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      scan_idx = ID_W'((int'(rr_ptr) + k) % NUM_REQ);
      if (!req_any && req_valid[scan_idx]) begin
        req_any = 1'b1;
        win_id  = scan_idx;
      end
    end
    if (req_any && !flush) begin
      req_ready[win_id] = 1'b1;
    end
  end

  assign grant    = req_any & ~flush;
  assign tag_exit = tag_valid[TAG_DEPTH-1];

  // Register winning operands (B sign flipped for subtract) and move the pointer.
  always_ff @(negedge clk_n or negedge rst_n) begin
    if (!rst_n) begin
      add_a  <= '0;
      add_b  <= '0;
      rr_ptr <= ID_W'(NUM_REQ - 1);
    end else if (grant) begin
      add_a  <= a_arr[win_id];
      add_b  <= {b_arr[win_id][31] ^ req_sub[win_id], b_arr[win_id][30:0]};
      rr_ptr <= win_id;
    end
  end

  // Shadow tag pipeline; shifts every edge, flush drops every valid bit.
  always_ff @(negedge clk_n or negedge rst_n) begin
    if (!rst_n) begin
      tag_valid <= '0;
      for (int s = 0; s < TAG_DEPTH; s++) begin
        tag_id[s] <= '0;
      end
    end else begin
      if (flush) begin
        tag_valid <= '0;
      end else begin
        tag_valid <= {tag_valid[TAG_DEPTH-2:0], grant};
      end
      tag_id[0] <= win_id;
      for (int s = 1; s < TAG_DEPTH; s++) begin
        tag_id[s] <= tag_id[s-1];
      end
    end
  end

  // Decode the exiting tag id into a per-requester strobe.
  always_comb begin
    rsp_onehot = '0;
    rsp_onehot[tag_id[TAG_DEPTH-1]] = 1'b1;
  end

  // Capture the adder result for the tag leaving the pipeline.
  always_ff @(negedge clk_n or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid <= '0;
      rsp_id    <= '0;
      rsp_data  <= '0;
    end else if (!flush && tag_exit) begin
      rsp_valid <= rsp_onehot;
      rsp_id    <= tag_id[TAG_DEPTH-1];
      rsp_data  <= add_result;
    end else begin
      rsp_valid <= '0;
    end
  end

  // Running count of valid tags: +1 per grant, -1 per response.
  always_ff @(negedge clk_n or negedge rst_n) begin
    if (!rst_n) begin
      inflight <= '0;
    end else if (flush) begin
      inflight <= '0;
    end else begin
      inflight <= inflight + {3'b000, grant} - {3'b000, tag_exit};
    end
  end

`ifdef FP_ARB_PERF_EN
  // Saturating issue and stall counters; only reset clears them.
  always_ff @(negedge clk_n or negedge rst_n) begin
    if (!rst_n) begin
      perf_issue_cnt <= '0;
      perf_stall_cnt <= '0;
    end else begin
      if (grant && (perf_issue_cnt != 32'hFFFF_FFFF)) begin
        perf_issue_cnt <= perf_issue_cnt + 32'd1;
      end
      if ((|req_valid) && !grant && (perf_stall_cnt != 32'hFFFF_FFFF)) begin
        perf_stall_cnt <= perf_stall_cnt + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_fp_add_arbiter.sv
// tb_fp_add_arbiter: directed bench for fp_add_arbiter with a stand-in
// six-stage adder. Define FP_ARB_PERF_EN to also exercise the perf counters.
module tb_fp_add_arbiter;

  logic         clk_n = 1'b1;
  logic         rst_n = 1'b0;
  logic         flush = 1'b0;
  logic [3:0]   req_valid = '0;
  logic [3:0]   req_sub = '0;
  logic [127:0] req_a = '0;
  logic [127:0] req_b = '0;
  logic [3:0]   req_ready;
  logic [31:0]  add_a;
  logic [31:0]  add_b;
  logic [31:0]  add_result;
  logic [3:0]   rsp_valid;
  logic [1:0]   rsp_id;
  logic [31:0]  rsp_data;
  logic [3:0]   inflight;
`ifdef FP_ARB_PERF_EN
  logic [31:0]  perf_issue_cnt;
  logic [31:0]  perf_stall_cnt;
`endif

  int errors = 0;
  int checks = 0;

  logic [31:0] op_a [4];
  logic [31:0] op_b_eff [4];
  logic [31:0] pipe [6];

  fp_add_arbiter #(.NUM_REQ(4), .ADD_LATENCY(6), .ID_W(2)) dut (
    .clk_n(clk_n), .rst_n(rst_n), .flush(flush),
    .req_valid(req_valid), .req_sub(req_sub), .req_a(req_a), .req_b(req_b),
    .req_ready(req_ready), .add_a(add_a), .add_b(add_b), .add_result(add_result),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_data(rsp_data), .inflight(inflight)
`ifdef FP_ARB_PERF_EN
    , .perf_issue_cnt(perf_issue_cnt), .perf_stall_cnt(perf_stall_cnt)
`endif
  );

  always #5 clk_n = ~clk_n;

  // Stand-in adder: exact for the directed sums, a distinct mix otherwise.
  function automatic logic [31:0] ref_add(input logic [31:0] a, input logic [31:0] b);
    if (a == 32'h3F80_0000 && b == 32'h4000_0000) return 32'h4040_0000;
    if (a == 32'h4040_0000 && b == 32'hBF80_0000) return 32'h4000_0000;
    return a ^ {b[15:0], b[31:16]};
  endfunction

  // Adder captures add_a/add_b on a falling edge; result valid 6 edges later inclusive.
  always @(negedge clk_n) begin
    pipe[0] <= ref_add(add_a, add_b);
    for (int k = 5; k > 0; k--) pipe[k] <= pipe[k-1];
  end
  assign add_result = pipe[5];

  task automatic cyc();
    @(posedge clk_n);
  endtask

  task automatic apply_reset();
    rst_n = 1'b0; flush = 1'b0; req_valid = '0; req_sub = '0;
    cyc(); cyc();
    rst_n = 1'b1;
  endtask

  task automatic set_ops();
    for (int i = 0; i < 4; i++) begin
      op_a[i] = 32'h3F80_0000 | (32'(i) << 8);
      req_a[32*i +: 32] = op_a[i];
      req_b[32*i +: 32] = 32'h4100_0000 | 32'(i);
      req_sub[i] = i[0];
      op_b_eff[i] = (32'h4100_0000 | 32'(i)) ^ (32'(i[0]) << 31);
    end
  endtask

  task automatic test_reset();
    apply_reset();
    checks++; if (add_a !== 32'h0) begin errors++; $display("FAIL reset_add_a: got %h expected 0", add_a); end
    checks++; if (add_b !== 32'h0) begin errors++; $display("FAIL reset_add_b: got %h expected 0", add_b); end
    checks++; if (rsp_valid !== 4'b0) begin errors++; $display("FAIL reset_rsp_valid: got %b expected 0000", rsp_valid); end
    checks++; if (rsp_data !== 32'h0) begin errors++; $display("FAIL reset_rsp_data: got %h expected 0", rsp_data); end
    checks++; if (inflight !== 4'd0) begin errors++; $display("FAIL reset_inflight: got %0d expected 0", inflight); end
    req_valid = 4'b1111; #1;
    checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL reset_rr_ptr: got %b expected 0001", req_ready); end
    req_valid = 4'b0000; #1;
    checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL idle_ready: got %b expected 0000", req_ready); end
`ifdef FP_ARB_PERF_EN
    checks++; if (perf_issue_cnt !== 32'd0) begin errors++; $display("FAIL reset_perf_issue: got %0d expected 0", perf_issue_cnt); end
    checks++; if (perf_stall_cnt !== 32'd0) begin errors++; $display("FAIL reset_perf_stall: got %0d expected 0", perf_stall_cnt); end
`endif
  endtask

  // Single op: grant same cycle, response strobe exactly 7 edges after the grant.
  task automatic test_single(input int r, input logic [31:0] a, input logic [31:0] b,
                             input logic sub, input logic [31:0] exp_b, input logic [31:0] exp_d);
    logic [3:0] oh;
    oh = 4'b0001 << r;
    req_a[32*r +: 32] = a; req_b[32*r +: 32] = b; req_sub[r] = sub;
    req_valid = oh; #1;
    checks++; if (req_ready !== oh) begin errors++; $display("FAIL single_ready: got %b expected %b", req_ready, oh); end
    cyc();
    req_valid = '0;
    checks++; if (add_a !== a) begin errors++; $display("FAIL single_add_a: got %h expected %h", add_a, a); end
    checks++; if (add_b !== exp_b) begin errors++; $display("FAIL single_add_b: got %h expected %h", add_b, exp_b); end
    for (int n = 2; n <= 9; n++) begin
      cyc();
      checks++;
      if (rsp_valid !== ((n == 8) ? oh : 4'b0000)) begin
        errors++; $display("FAIL single_rsp_valid n=%0d: got %b expected %b", n, rsp_valid, (n == 8) ? oh : 4'b0000);
      end
      checks++;
      if (inflight !== ((n < 8) ? 4'd1 : 4'd0)) begin
        errors++; $display("FAIL single_inflight n=%0d: got %0d expected %0d", n, inflight, (n < 8) ? 1 : 0);
      end
      if (n == 8) begin
        checks++; if (rsp_id !== 2'(r)) begin errors++; $display("FAIL single_rsp_id: got %0d expected %0d", rsp_id, r); end
        checks++; if (rsp_data !== exp_d) begin errors++; $display("FAIL single_rsp_data: got %h expected %h", rsp_data, exp_d); end
      end
    end
    checks++; if (add_a !== a) begin errors++; $display("FAIL hold_add_a: got %h expected %h", add_a, a); end
  endtask

  task automatic test_round_robin();
    int peak;
    int g;
    int exp_inf;
    peak = 0;
    apply_reset();
    set_ops();
    for (int n = 1; n <= 16; n++) begin
      if (n <= 8) begin
        req_valid = 4'b1111; #1;
        checks++;
        if (req_ready !== (4'b0001 << ((n - 1) % 4))) begin
          errors++; $display("FAIL rr_grant n=%0d: got %b expected %b", n, req_ready, 4'b0001 << ((n - 1) % 4));
        end
      end else begin
        req_valid = 4'b0000;
      end
      cyc();
      g = n - 8;
      if (g >= 0 && g < 8) begin
        checks++;
        if (rsp_valid !== (4'b0001 << (g % 4))) begin
          errors++; $display("FAIL rr_rsp_valid n=%0d: got %b expected %b", n, rsp_valid, 4'b0001 << (g % 4));
        end
        checks++;
        if (rsp_id !== 2'(g % 4)) begin errors++; $display("FAIL rr_rsp_id n=%0d: got %0d expected %0d", n, rsp_id, g % 4); end
        checks++;
        if (rsp_data !== ref_add(op_a[g % 4], op_b_eff[g % 4])) begin
          errors++; $display("FAIL rr_rsp_data n=%0d: got %h expected %h", n, rsp_data, ref_add(op_a[g % 4], op_b_eff[g % 4]));
        end
      end else begin
        checks++;
        if (rsp_valid !== 4'b0000) begin errors++; $display("FAIL rr_rsp_idle n=%0d: got %b expected 0000", n, rsp_valid); end
      end
      exp_inf = ((n < 8) ? n : 8) - ((n <= 7) ? 0 : ((n - 7 > 8) ? 8 : n - 7));
      checks++;
      if (inflight !== 4'(exp_inf)) begin errors++; $display("FAIL rr_inflight n=%0d: got %0d expected %0d", n, inflight, exp_inf); end
      if (int'(inflight) > peak) peak = int'(inflight);
    end
    checks++; if (peak != 7) begin errors++; $display("FAIL rr_peak: got %0d expected 7", peak); end
  endtask

  task automatic test_flush();
    apply_reset();
    set_ops();
    for (int n = 1; n <= 3; n++) begin
      req_valid = 4'b0111; #1;
      checks++;
      if (req_ready !== (4'b0001 << (n - 1))) begin
        errors++; $display("FAIL flush_issue n=%0d: got %b expected %b", n, req_ready, 4'b0001 << (n - 1));
      end
      cyc();
    end
    req_valid = 4'b0000;
    cyc(); cyc();
    checks++; if (inflight !== 4'd3) begin errors++; $display("FAIL flush_pre_inflight: got %0d expected 3", inflight); end
    flush = 1'b1; req_valid = 4'b1111; #1;
    checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL flush_masks_grant: got %b expected 0000", req_ready); end
    cyc();
    flush = 1'b0;
    checks++; if (inflight !== 4'd0) begin errors++; $display("FAIL flush_inflight: got %0d expected 0", inflight); end
    #1;
    checks++; if (req_ready !== 4'b1000) begin errors++; $display("FAIL flush_resume: got %b expected 1000", req_ready); end
    cyc();
    req_valid = 4'b0000;
    checks++; if (inflight !== 4'd1) begin errors++; $display("FAIL flush_post_inflight: got %0d expected 1", inflight); end
    for (int n = 8; n <= 16; n++) begin
      cyc();
      checks++;
      if (rsp_valid !== ((n == 14) ? 4'b1000 : 4'b0000)) begin
        errors++; $display("FAIL flush_rsp n=%0d: got %b expected %b", n, rsp_valid, (n == 14) ? 4'b1000 : 4'b0000);
      end
    end
  endtask

  task automatic test_reset_midflight();
    apply_reset();
    set_ops();
    for (int n = 1; n <= 6; n++) begin
      req_valid = 4'b1111;
      cyc();
    end
    req_valid = 4'b0000;
    cyc(); cyc();
    checks++; if (inflight !== 4'd5) begin errors++; $display("FAIL mid_inflight: got %0d expected 5", inflight); end
    checks++;
    if (rsp_data !== ref_add(op_a[0], op_b_eff[0])) begin
      errors++; $display("FAIL mid_rsp_data: got %h expected %h", rsp_data, ref_add(op_a[0], op_b_eff[0]));
    end
    rst_n = 1'b0; #1;
    checks++; if (add_a !== 32'h0) begin errors++; $display("FAIL mid_rst_add_a: got %h expected 0", add_a); end
    checks++; if (add_b !== 32'h0) begin errors++; $display("FAIL mid_rst_add_b: got %h expected 0", add_b); end
    checks++; if (rsp_valid !== 4'b0) begin errors++; $display("FAIL mid_rst_rsp_valid: got %b expected 0000", rsp_valid); end
    checks++; if (rsp_data !== 32'h0) begin errors++; $display("FAIL mid_rst_rsp_data: got %h expected 0", rsp_data); end
    checks++; if (inflight !== 4'd0) begin errors++; $display("FAIL mid_rst_inflight: got %0d expected 0", inflight); end
    cyc(); cyc();
    rst_n = 1'b1;
    for (int n = 1; n <= 10; n++) begin
      cyc();
      checks++; if (rsp_valid !== 4'b0) begin errors++; $display("FAIL mid_no_rsp n=%0d: got %b expected 0000", n, rsp_valid); end
    end
    req_valid = 4'b0110; #1;
    checks++; if (req_ready !== 4'b0010) begin errors++; $display("FAIL mid_first_grant: got %b expected 0010", req_ready); end
    cyc();
    req_valid = 4'b0000;
    checks++; if (add_a !== op_a[1]) begin errors++; $display("FAIL mid_add_a: got %h expected %h", add_a, op_a[1]); end
  endtask

`ifdef FP_ARB_PERF_EN
  task automatic test_perf();
    apply_reset();
    set_ops();
    req_valid = 4'b0001;
    for (int n = 0; n < 10; n++) cyc();
    flush = 1'b1;
    cyc(); cyc();
    flush = 1'b0; req_valid = 4'b0000;
    cyc();
    checks++; if (perf_issue_cnt !== 32'd10) begin errors++; $display("FAIL perf_issue: got %0d expected 10", perf_issue_cnt); end
    checks++; if (perf_stall_cnt !== 32'd2) begin errors++; $display("FAIL perf_stall: got %0d expected 2", perf_stall_cnt); end
  endtask
`endif

  initial begin
    test_reset();
    test_single(0, 32'h3F80_0000, 32'h4000_0000, 1'b0, 32'h4000_0000, 32'h4040_0000);
    test_single(2, 32'h4040_0000, 32'h3F80_0000, 1'b1, 32'hBF80_0000, 32'h4000_0000);
    test_round_robin();
    test_flush();
    test_reset_midflight();
`ifdef FP_ARB_PERF_EN
    test_perf();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
